// File: rtl/vec_ff_fifo_reg.sv
// vec_ff_fifo_reg: FIFO-buffered multi-channel pin formatter.
// Pattern vectors are queued in a DEPTH-entry FIFO and popped into an active
// register on every leading edge of CYCLE. Each channel then shapes its pin
// output with its own 2-bit format code (R0 / R1 / DNRZ_L / DNRZ_T). Format
// codes are double-buffered: CFG_WE writes a pending copy that only becomes
// active at the next leading edge.
module vec_ff_fifo_reg #(
  parameter int CHANNELS = 8,
  parameter int ADDR_W   = 2
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    CYCLE,
  input  logic                    PUSH,
  input  logic [CHANNELS-1:0]     D,
  input  logic                    FLUSH,
  input  logic                    CFG_WE,
  input  logic [2*CHANNELS-1:0]   FF_CFG,
  input  logic                    CLR_FLAGS,
  output logic [CHANNELS-1:0]     Q,
  output logic                    FULL,
  output logic                    EMPTY,
  output logic [ADDR_W:0]         COUNT,
  output logic                    UNDERRUN,
  output logic                    OVERFLOW
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  // Format codes
  localparam logic [1:0] FMT_R0     = 2'b00;
  localparam logic [1:0] FMT_R1     = 2'b01;
  localparam logic [1:0] FMT_DNRZ_L = 2'b10;
  localparam logic [1:0] FMT_DNRZ_T = 2'b11;

  // Control state
  logic                  cyc_q;
  logic [ADDR_W:0]       count_q,    count_d;
  logic [ADDR_W-1:0]     wr_ptr_q,   wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q,   rd_ptr_d;
  logic [CHANNELS-1:0]   act_vec_q,  act_vec_d;
  logic [2*CHANNELS-1:0] pend_cfg_q, pend_cfg_d;
  logic [2*CHANNELS-1:0] act_cfg_q,  act_cfg_d;
  logic [CHANNELS-1:0]   q_q,        q_d;
  logic                  und_q,      und_d;
  logic                  ovf_q,      ovf_d;

  // FIFO storage (data only, never reset)
  logic [CHANNELS-1:0]   mem_q [DEPTH];

  // Decoded events
  logic lead;
  logic trail;
  logic fifo_empty;
  logic fifo_full;
  logic pop_ok;
  logic push_ok;
  logic push_drop;
  logic underrun_set;

  // Per-channel output shaping: what the pin does on this clock given the
  // channel's format, the cycle edge seen, the data bit and its current level.
  function automatic logic fmt_bit(input logic [1:0] code,
                                   input logic       ld,
                                   input logic       tr,
                                   input logic       v,
                                   input logic       cur);
    logic r;
    r = cur;
    if (ld) begin
      // Every format except DNRZ_T launches data at the leading edge.
      if (code != FMT_DNRZ_T) r = v;
    end else if (tr) begin
      case (code)
        FMT_R0:     r = 1'b0;
        FMT_R1:     r = 1'b1;
        FMT_DNRZ_L: r = cur;
        FMT_DNRZ_T: r = v;
        default:    r = cur;
      endcase
    end
    return r;
  endfunction

  // Edge detection, FIFO arbitration and flag set conditions.
  always_comb begin
    lead         = CYCLE & ~cyc_q;
    trail        = ~CYCLE & cyc_q;
    fifo_empty   = (count_q == '0);
    fifo_full    = (count_q == DEPTH_C);
    // A flush turns any concurrent leading edge into an empty pop.
    pop_ok       = lead & ~FLUSH & ~fifo_empty;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    push_ok      = PUSH & ~FLUSH & (~fifo_full | pop_ok);
    push_drop    = PUSH & ~FLUSH & ~push_ok;
    underrun_set = lead & (FLUSH | fifo_empty);
  end

  // Next-state for occupancy and pointers; pointers wrap naturally at DEPTH.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (FLUSH) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
        2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Next-state for active vector, config buffers, pin outputs and flags.
  always_comb begin
    act_vec_d  = pop_ok ? mem_q[rd_ptr_q] : act_vec_q;
    pend_cfg_d = CFG_WE ? FF_CFG : pend_cfg_q;
    // Pending (including a same-cycle write) is promoted before formatting,
    // so the new format governs the vector popped on this edge.
    act_cfg_d  = lead ? pend_cfg_d : act_cfg_q;
    q_d        = q_q;
    for (int i = 0; i < CHANNELS; i++) begin
      q_d[i] = fmt_bit(act_cfg_d[2*i +: 2], lead, trail, act_vec_d[i], q_q[i]);
    end
    // A set condition wins over a simultaneous clear.
    und_d = underrun_set | (und_q & ~CLR_FLAGS);
    ovf_d = push_drop    | (ovf_q & ~CLR_FLAGS);
  end

  // Control and output registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cyc_q      <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      act_vec_q  <= '0;
      pend_cfg_q <= '0;
      act_cfg_q  <= '0;
      q_q        <= '0;
      und_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      cyc_q      <= CYCLE;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      act_vec_q  <= act_vec_d;
      pend_cfg_q <= pend_cfg_d;
      act_cfg_q  <= act_cfg_d;
      q_q        <= q_d;
      und_q      <= und_d;
      ovf_q      <= ovf_d;
    end
  end

  // FIFO write port; contents are only meaningful below COUNT.
  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= D;
  end

  assign Q        = q_q;
  assign COUNT    = count_q;
  assign FULL     = fifo_full;
  assign EMPTY    = fifo_empty;
  assign UNDERRUN = und_q;
  assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_vec_ff_fifo_reg.sv
// Directed bench for vec_ff_fifo_reg (CHANNELS=8, ADDR_W=2).
module tb_vec_ff_fifo_reg;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        CYCLE;
  logic        PUSH;
  logic [7:0]  D;
  logic        FLUSH;
  logic        CFG_WE;
  logic [15:0] FF_CFG;
  logic        CLR_FLAGS;
  logic [7:0]  Q;
  logic        FULL;
  logic        EMPTY;
  logic [2:0]  COUNT;
  logic        UNDERRUN;
  logic        OVERFLOW;

  int errors = 0;
  int checks = 0;

  vec_ff_fifo_reg #(.CHANNELS(8), .ADDR_W(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .CYCLE(CYCLE), .PUSH(PUSH), .D(D),
    .FLUSH(FLUSH), .CFG_WE(CFG_WE), .FF_CFG(FF_CFG), .CLR_FLAGS(CLR_FLAGS),
    .Q(Q), .FULL(FULL), .EMPTY(EMPTY), .COUNT(COUNT),
    .UNDERRUN(UNDERRUN), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; CYCLE = 1'b0; PUSH = 1'b0; D = '0; FLUSH = 1'b0;
    CFG_WE = 1'b0; FF_CFG = '0; CLR_FLAGS = 1'b0;
    #3;
    checks++; if (Q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h want 00", Q); end
    checks++; if (COUNT !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", COUNT); end
    checks++; if (EMPTY !== 1'b1 || FULL !== 1'b0) begin errors++; $display("FAIL reset_empty_full: got %b%b want 10", EMPTY, FULL); end
    checks++; if (UNDERRUN !== 1'b0 || OVERFLOW !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b%b want 00", UNDERRUN, OVERFLOW); end
    step();
    RST_N = 1'b1;
    step();
  endtask

  task automatic test_r0();
    CFG_WE = 1'b1; FF_CFG = 16'h0000; PUSH = 1'b1; D = 8'hA5;
    step();
    CFG_WE = 1'b0; D = 8'h3C;
    step();
    PUSH = 1'b0;
    checks++; if (COUNT !== 3'd2) begin errors++; $display("FAIL r0_count2: got %0d want 2", COUNT); end
    CYCLE = 1'b1; step();
    checks++; if (Q !== 8'hA5) begin errors++; $display("FAIL r0_lead1: got %h want a5", Q); end
    checks++; if (COUNT !== 3'd1) begin errors++; $display("FAIL r0_count1: got %0d want 1", COUNT); end
    CYCLE = 1'b0; step();
    checks++; if (Q !== 8'h00) begin errors++; $display("FAIL r0_trail1: got %h want 00", Q); end
    CYCLE = 1'b1; step();
    checks++; if (Q !== 8'h3C) begin errors++; $display("FAIL r0_lead2: got %h want 3c", Q); end
    checks++; if (COUNT !== 3'd0 || EMPTY !== 1'b1) begin errors++; $display("FAIL r0_count0: got %0d/%b want 0/1", COUNT, EMPTY); end
    CYCLE = 1'b0; step();
    checks++; if (Q !== 8'h00) begin errors++; $display("FAIL r0_trail2: got %h want 00", Q); end
  endtask

  task automatic test_r1_dnrz_l();
    CFG_WE = 1'b1; FF_CFG = 16'h5555; PUSH = 1'b1; D = 8'h0F;
    step();
    CFG_WE = 1'b0; PUSH = 1'b0;
    CYCLE = 1'b1; step();
    checks++; if (Q !== 8'h0F) begin errors++; $display("FAIL r1_lead: got %h want 0f", Q); end
    CYCLE = 1'b0; step();
    checks++; if (Q !== 8'hFF) begin errors++; $display("FAIL r1_trail: got %h want ff", Q); end
    CFG_WE = 1'b1; FF_CFG = 16'hAAAA; PUSH = 1'b1; D = 8'h0F;
    step();
    CFG_WE = 1'b0; PUSH = 1'b0;
    CYCLE = 1'b1; step();
    checks++; if (Q !== 8'h0F) begin errors++; $display("FAIL dnrzl_lead: got %h want 0f", Q); end
    CYCLE = 1'b0; step();
    checks++; if (Q !== 8'h0F) begin errors++; $display("FAIL dnrzl_trail_hold: got %h want 0f", Q); end
  endtask

  task automatic test_dnrz_t();
    CFG_WE = 1'b1; FF_CFG = 16'hFFFF; PUSH = 1'b1; D = 8'h81;
    step();
    CFG_WE = 1'b0; PUSH = 1'b0;
    CYCLE = 1'b1; step();
    checks++; if (Q !== 8'h0F) begin errors++; $display("FAIL dnrzt_lead_hold: got %h want 0f", Q); end
    CYCLE = 1'b0; step();
    checks++; if (Q !== 8'h81) begin errors++; $display("FAIL dnrzt_trail: got %h want 81", Q); end
  endtask

  task automatic test_overflow_flush();
    logic [7:0] words [4];
    words = '{8'h11, 8'h22, 8'h33, 8'h44};
    PUSH = 1'b1;
    for (int i = 0; i < 4; i++) begin
      D = words[i];
      step();
    end
    checks++; if (COUNT !== 3'd4 || FULL !== 1'b1) begin errors++; $display("FAIL fill_full: got %0d/%b want 4/1", COUNT, FULL); end
    checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL fill_no_ovf: got %b want 0", OVERFLOW); end
    D = 8'h55; step();
    checks++; if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", OVERFLOW); end
    checks++; if (COUNT !== 3'd4 || FULL !== 1'b1) begin errors++; $display("FAIL ovf_count: got %0d/%b want 4/1", COUNT, FULL); end
    // Push together with a pop while full: accepted, occupancy unchanged.
    D = 8'h66; CYCLE = 1'b1; step();
    checks++; if (COUNT !== 3'd4) begin errors++; $display("FAIL pushpop_count: got %0d want 4", COUNT); end
    checks++; if (Q !== 8'h81) begin errors++; $display("FAIL pushpop_q_hold: got %h want 81", Q); end
    PUSH = 1'b0; CYCLE = 1'b0; step();
    checks++; if (Q !== 8'h11) begin errors++; $display("FAIL pushpop_trail: got %h want 11", Q); end
    CLR_FLAGS = 1'b1; step();
    checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", OVERFLOW); end
    PUSH = 1'b1; D = 8'h99; step();
    checks++; if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_set_beats_clr: got %b want 1", OVERFLOW); end
    PUSH = 1'b0; step();
    CLR_FLAGS = 1'b0;
    checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL ovf_clear2: got %b want 0", OVERFLOW); end
    FLUSH = 1'b1; PUSH = 1'b1; D = 8'hAA; step();
    FLUSH = 1'b0; PUSH = 1'b0;
    checks++; if (COUNT !== 3'd0 || EMPTY !== 1'b1) begin errors++; $display("FAIL flush_count: got %0d/%b want 0/1", COUNT, EMPTY); end
    checks++; if (Q !== 8'h11 || OVERFLOW !== 1'b0) begin errors++; $display("FAIL flush_untouched: got %h/%b want 11/0", Q, OVERFLOW); end
  endtask

  task automatic test_underrun_cfg();
    CFG_WE = 1'b1; FF_CFG = 16'h0000; step();
    CFG_WE = 1'b0;
    CYCLE = 1'b1; step();
    checks++; if (UNDERRUN !== 1'b1) begin errors++; $display("FAIL und_set: got %b want 1", UNDERRUN); end
    checks++; if (Q !== 8'h11) begin errors++; $display("FAIL und_active_hold: got %h want 11", Q); end
    CFG_WE = 1'b1; FF_CFG = 16'h5555; step();
    CFG_WE = 1'b0;
    checks++; if (Q !== 8'h11) begin errors++; $display("FAIL midcfg_no_edge: got %h want 11", Q); end
    CYCLE = 1'b0; step();
    checks++; if (Q !== 8'h00) begin errors++; $display("FAIL midcfg_old_trail: got %h want 00", Q); end
    // Lead with a push into an empty FIFO: underrun, word stored, no bypass.
    CYCLE = 1'b1; PUSH = 1'b1; D = 8'h77; step();
    PUSH = 1'b0;
    checks++; if (Q !== 8'h11 || COUNT !== 3'd1) begin errors++; $display("FAIL lead_push_empty: got %h/%0d want 11/1", Q, COUNT); end
    CYCLE = 1'b0; step();
    checks++; if (Q !== 8'hFF) begin errors++; $display("FAIL newcfg_trail: got %h want ff", Q); end
    CLR_FLAGS = 1'b1; step();
    CLR_FLAGS = 1'b0;
    checks++; if (UNDERRUN !== 1'b0) begin errors++; $display("FAIL und_clear: got %b want 0", UNDERRUN); end
    CYCLE = 1'b1; step();
    checks++; if (Q !== 8'h77 || COUNT !== 3'd0 || UNDERRUN !== 1'b0) begin errors++; $display("FAIL pop_stored: got %h/%0d/%b want 77/0/0", Q, COUNT, UNDERRUN); end
    CYCLE = 1'b0; step();
    checks++; if (Q !== 8'hFF) begin errors++; $display("FAIL pop_stored_trail: got %h want ff", Q); end
  endtask

  task automatic test_reset_mid();
    PUSH = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      D = 8'(i);
      step();
    end
    PUSH = 1'b0;
    checks++; if (Q !== 8'hFF || COUNT !== 3'd3) begin errors++; $display("FAIL pre_reset: got %h/%0d want ff/3", Q, COUNT); end
    CYCLE = 1'b1;
    #2 RST_N = 1'b0;
    #1;
    checks++; if (Q !== 8'h00 || COUNT !== 3'd0 || EMPTY !== 1'b1) begin errors++; $display("FAIL async_reset: got %h/%0d/%b want 00/0/1", Q, COUNT, EMPTY); end
    #2 RST_N = 1'b1;
    step();
    checks++; if (UNDERRUN !== 1'b1 || Q !== 8'h00) begin errors++; $display("FAIL release_lead: got %b/%h want 1/00", UNDERRUN, Q); end
    CLR_FLAGS = 1'b1; step();
    CLR_FLAGS = 1'b0;
    step();
    checks++; if (UNDERRUN !== 1'b0) begin errors++; $display("FAIL single_lead: got %b want 0", UNDERRUN); end
    CYCLE = 1'b0; step();
  endtask

  initial begin
    test_reset();
    test_r0();
    test_r1_dnrz_l();
    test_dnrz_t();
    test_overflow_flush();
    test_underrun_cfg();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
